// File: rtl/ext_ref_freq_meter.sv
// Windowed edge counter for the external 10 MHz reference, sampled in the CLK_LOW domain.
// Optional build macro EXT_MEAS_STUCK_DET_EN enables the stuck-level run detector.
module ext_ref_freq_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_LEN  = 16,
    parameter int WIN_LEN     = 65000,
    parameter int CNT_LO      = 12740,
    parameter int CNT_HI      = 13260,
    parameter int STUCK_MAX   = 64
) (
    input  logic        CLK_LOW,
    input  logic        ext_clk_cnt_rst2,
    input  logic        EXT_10M_INPUT,
    output logic        meas_busy,
    output logic        meas_done,
    output logic [13:0] meas_count,
    output logic        in_range,
    output logic        cnt_ovf,
    output logic        stuck
);

    typedef enum logic [2:0] {RST_IDLE, SETTLE, COUNT, EVAL, DONE} state_t;

    localparam logic [16:0] SETTLE_END = 17'(SETTLE_LEN - 1);
    localparam logic [16:0] WIN_END    = 17'(WIN_LEN - 1);
    localparam logic [13:0] CNT_MAX    = 14'h3fff;
    localparam logic [13:0] LO         = 14'(CNT_LO);
    localparam logic [13:0] HI         = 14'(CNT_HI);
    localparam bit          RANGE_OK   = (CNT_LO <= CNT_HI);

    state_t state, state_nxt;
    logic [16:0] cyc;
    logic [SYNC_STAGES-1:0] sync_q;
    logic        dly_q;
    logic        lvl;
    logic        rise;
    logic [13:0] edge_cnt;
    logic        ovf_q;
    logic        done_q;

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~dly_q;

    always_ff @(posedge CLK_LOW or posedge ext_clk_cnt_rst2) begin
        if (ext_clk_cnt_rst2) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], EXT_10M_INPUT};
            dly_q  <= lvl;
        end
    end

    always_ff @(posedge CLK_LOW or posedge ext_clk_cnt_rst2) begin
        if (ext_clk_cnt_rst2) begin
            state <= RST_IDLE;
            cyc   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cyc <= '0;
            else if (state == SETTLE || state == COUNT)
                cyc <= cyc + 17'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        meas_busy = 1'b0;
        case (state)
            RST_IDLE: state_nxt = SETTLE;
            SETTLE: begin
                meas_busy = 1'b1;
                if (cyc == SETTLE_END) state_nxt = COUNT;
            end
            COUNT: begin
                meas_busy = 1'b1;
                if (cyc == WIN_END) state_nxt = EVAL;
            end
            EVAL: begin
                meas_busy = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = RST_IDLE;
        endcase
    end

    // Edge counter saturates; ovf marks that the true count is unknown.
    always_ff @(posedge CLK_LOW or posedge ext_clk_cnt_rst2) begin
        if (ext_clk_cnt_rst2) begin
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (state == COUNT && rise && edge_cnt != CNT_MAX) begin
            edge_cnt <= edge_cnt + 14'd1;
            if (edge_cnt == CNT_MAX - 14'd1) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK_LOW or posedge ext_clk_cnt_rst2) begin
        if (ext_clk_cnt_rst2) begin
            meas_count <= '0;
            in_range   <= 1'b0;
            cnt_ovf    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == EVAL);
            if (state == EVAL) begin
                meas_count <= edge_cnt;
                in_range   <= RANGE_OK && !ovf_q && (edge_cnt >= LO) && (edge_cnt <= HI);
                cnt_ovf    <= ovf_q;
            end
        end
    end

    assign meas_done = done_q;

`ifdef EXT_MEAS_STUCK_DET_EN
    localparam int              RUN_W   = $clog2(STUCK_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_MAX);

    logic [RUN_W-1:0] run_q;
    logic             stuck_q;

    always_ff @(posedge CLK_LOW or posedge ext_clk_cnt_rst2) begin
        if (ext_clk_cnt_rst2) begin
            run_q   <= '0;
            stuck_q <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            if (state != COUNT || lvl != dly_q) begin
                run_q <= '0;
            end else if (run_q != RUN_MAX) begin
                run_q <= run_q + 1'b1;
                if (run_q == RUN_MAX - 1'b1) stuck_q <= 1'b1;
            end
            if (state == EVAL) stuck <= stuck_q;
        end
    end
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_ext_ref_freq_meter.sv
// Randomized-phase bench for ext_ref_freq_meter with a sample-level reference model.
`timescale 1ns/1ps
module tb_ext_ref_freq_meter;
    localparam int SETTLE = 16;
    localparam int WIN    = 1000;
    localparam int LO     = 196;
    localparam int HI     = 204;
    localparam int SMAX   = 64;
    localparam int T_DONE = SETTLE + WIN + 1;   // edge index (0 = first edge after release)
    localparam int WIN_B  = 65000;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst = 1'b1, pin = 1'b0;
    logic        busy, done, rng, ovf, stk;
    logic [13:0] cnt;
    logic        rst_b = 1'b1, pin_b = 1'b0;
    logic        busy_b, done_b, rng_b, ovf_b, stk_b;
    logic [13:0] cnt_b;

    ext_ref_freq_meter #(.SYNC_STAGES(2), .SETTLE_LEN(SETTLE), .WIN_LEN(WIN),
        .CNT_LO(LO), .CNT_HI(HI), .STUCK_MAX(SMAX)) dut (
        .CLK_LOW(clk), .ext_clk_cnt_rst2(rst), .EXT_10M_INPUT(pin),
        .meas_busy(busy), .meas_done(done), .meas_count(cnt),
        .in_range(rng), .cnt_ovf(ovf), .stuck(stk));

    ext_ref_freq_meter #(.SYNC_STAGES(2), .SETTLE_LEN(SETTLE), .WIN_LEN(WIN_B),
        .CNT_LO(LO), .CNT_HI(HI), .STUCK_MAX(SMAX)) dut_b (
        .CLK_LOW(clk), .ext_clk_cnt_rst2(rst_b), .EXT_10M_INPUT(pin_b),
        .meas_busy(busy_b), .meas_done(done_b), .meas_count(cnt_b),
        .in_range(rng_b), .cnt_ovf(ovf_b), .stuck(stk_b));

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input int got, input int lo, input int hi);
        n_cmp++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Input generators: phase accumulator in units of 1/50000 of a CLK_LOW cycle,
    // freq in kHz; updated on the falling edge so the pin is stable at sampling.
    int freq = 10000, ph = 0, ph_b = 0;
    bit const_lvl = 1'b0;
    always @(negedge clk) begin
        if (freq == 0) pin = const_lvl;
        else begin
            ph  = (ph + freq) % 50000;
            pin = (ph < 25000);
        end
        ph_b  = (ph_b + 24000) % 50000;
        pin_b = (ph_b < 25000);
    end

    // Reference model: record pin samples per edge since release, evaluate once
    // the window result is due.  A pin rise seen at sample m reaches the counter
    // two edges later, so counted rises are m in [SETTLE-1, SETTLE+WIN-2].
    int k = -1;
    bit samp [0:2047];
    int e_cnt = 0;
    bit e_rng = 0, e_ovf = 0, e_stk = 0;

    always @(posedge clk) begin
        if (rst) begin
            k = -1; e_cnt = 0; e_rng = 0; e_ovf = 0; e_stk = 0;
        end else begin
            k++;
            if (k < 2048) samp[k] = pin;
            if (k == T_DONE) begin
                int r, run, mx;
                r = 0; run = 1; mx = 1;
                for (int m = SETTLE - 1; m <= SETTLE + WIN - 2; m++) begin
                    if (!samp[m-1] && samp[m]) r++;
                    run = (samp[m] == samp[m-1]) ? run + 1 : 1;
                    if (run > mx) mx = run;
                end
                e_ovf = (r >= 16383);
                e_cnt = e_ovf ? 16383 : r;
                e_rng = !e_ovf && e_cnt >= LO && e_cnt <= HI;
`ifdef EXT_MEAS_STUCK_DET_EN
                e_stk = (mx > SMAX);
`else
                e_stk = 1'b0;
`endif
            end
        end
    end

    int n_done = 0, done_k = -1;
    always @(posedge clk) begin
        bit x_busy, x_done;
        #5;
        x_busy = !rst && k >= 0 && k < T_DONE;
        x_done = !rst && k == T_DONE;
        if (done) begin n_done++; done_k = k; end
        n_cmp++;
        if (busy !== x_busy || done !== x_done || int'(cnt) != e_cnt || rng !== e_rng
            || ovf !== e_ovf || stk !== e_stk) begin
            n_fail++;
            $display("FAIL cycle k=%0d: got busy=%b done=%b cnt=%0d rng=%b ovf=%b stk=%b, required busy=%b done=%b cnt=%0d rng=%b ovf=%b stk=%b",
                     k, busy, done, cnt, rng, ovf, stk, x_busy, x_done, e_cnt, e_rng, e_ovf, e_stk);
        end
    end

    task automatic release_rst(input int f, input bit lvl);
        @(negedge clk);
        rst = 1'b1;
        freq = f; const_lvl = lvl; ph = $urandom_range(0, 49999);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic window(input string name, input int f, input bit lvl, input int lo, input int hi);
        int d0;
        d0 = n_done;
        release_rst(f, lvl);
        repeat (T_DONE + 3) @(posedge clk);
        @(negedge clk);
        chk({name, "_pulses"}, n_done - d0, 1, 1);
        chk({name, "_done_at"}, done_k, T_DONE, T_DONE);
        chk({name, "_count"}, int'(cnt), lo, hi);
    endtask

    bit b_fin = 0;
    initial begin
        int w;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        w = 0;
        while (!done_b && w < WIN_B + 200) begin @(posedge clk); #5; w++; end
        chk("ovf_done_seen", int'(done_b), 1, 1);
        chk("ovf_flag", int'(ovf_b), 1, 1);
        chk("ovf_count", int'(cnt_b), 16383, 16383);
        chk("ovf_in_range", int'(rng_b), 0, 0);
        b_fin = 1;
    end

    initial begin
        int d0, w;
        repeat (4) @(negedge clk);
        chk("reset_busy", int'(busy), 0, 0);
        chk("reset_count", int'(cnt), 0, 0);

        window("f10M", 10000, 0, 200, 200);
        chk("f10M_in_range", int'(rng), 1, 1);
        chk("f10M_stuck", int'(stk), 0, 0);
        chk("f10M_ovf", int'(ovf), 0, 0);

        window("f9M5", 9500, 0, 189, 191);
        chk("f9M5_in_range", int'(rng), 0, 0);

        window("f10M2", 10200, 0, 203, 205);

        window("const0", 0, 0, 0, 0);
        chk("const0_in_range", int'(rng), 0, 0);
`ifdef EXT_MEAS_STUCK_DET_EN
        chk("const0_stuck", int'(stk), 1, 1);
`else
        chk("const0_stuck", int'(stk), 0, 0);
`endif
        window("const1", 0, 1, 0, 0);

        // Reset in the middle of the counting window
        d0 = n_done;
        release_rst(10000, 0);
        repeat (SETTLE + 500) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0, 0);
        chk("midrst_count", int'(cnt), 0, 0);
        repeat (3) @(negedge clk);
        chk("midrst_no_pulse", n_done - d0, 0, 0);
        rst = 1'b0;
        repeat (T_DONE + 3) @(posedge clk);
        @(negedge clk);
        chk("midrst_fresh_pulses", n_done - d0, 1, 1);
        chk("midrst_fresh_done_at", done_k, T_DONE, T_DONE);

        // Three back-to-back restarts at 1100-cycle spacing
        d0 = n_done;
        for (int i = 0; i < 3; i++) begin
            release_rst(10000, 0);
            repeat (1100 - 4) @(negedge clk);
        end
        chk("three_pulses", n_done - d0, 3, 3);

        for (int i = 0; i < 4; i++) begin
            int f;
            f = $urandom_range(9500, 10500);
            window("rand", f, 0, (f * WIN) / 50000 - 1, (f * WIN) / 50000 + 1);
        end

        w = 0;
        while (!b_fin && w < WIN_B + 1000) begin @(posedge clk); w++; end
        chk("ovf_finished", int'(b_fin), 1, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
